// File: rtl/vertical_feed_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : vertical_feed_scheduler
// Description : Pops the 16 column FIFOs of the vertical input buffer in a
//               diagonal (systolic) skew. Column k starts k ticks after
//               column 0 and delivers len bytes. The whole wavefront
//               advances in lockstep, so any starved active column stalls
//               every column.
// Option      : VFS_STALL_CNT_EN - when defined, stall_cnt counts RUN cycles
//               without an advance. When undefined, stall_cnt is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module vertical_feed_scheduler #(
  parameter int COLS  = 16,
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic [COLS-1:0]  fifo_RREADY_col,
  output logic [COLS-1:0]  fifo_RVALID_col,
  output logic             pe_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] stall_cnt
);

  // Tick counter is wide enough to hold len + COLS - 2 without wrapping.
  localparam int T_W = LEN_W + 5;
  localparam logic [T_W-1:0] c_LAST_OFS = T_W'(COLS - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [T_W-1:0]   r_t;
  logic [LEN_W-1:0] r_len_q;
  logic [T_W-1:0]   w_len_ext;
  logic [T_W-1:0]   w_last_t;
  logic [COLS-1:0]  w_active;
  logic [COLS-1:0]  w_col_ok;
  logic             w_advance;
  logic             w_accept;

  assign w_len_ext = T_W'(r_len_q);
  assign w_last_t  = w_len_ext + c_LAST_OFS;
  assign w_accept  = (r_state == S_IDLE) && start;

  // Column k is inside its delivery window when k <= t < k + len.
  for (genvar k = 0; k < COLS; k++) begin : g_col
    localparam logic [T_W-1:0] c_K = T_W'(k);
    assign w_active[k] = (r_t >= c_K) && (r_t < (c_K + w_len_ext));
  end

  // A column blocks the wavefront only while it is active and has no data.
  assign w_col_ok  = ~w_active | fifo_RREADY_col;
  assign w_advance = (r_state == S_RUN) && !abort && (&w_col_ok);

  assign fifo_RVALID_col = {COLS{w_advance}} & w_active;
  assign pe_en           = w_advance;
  assign busy            = (r_state == S_RUN);
  // An abort landing on the DONE cycle suppresses the completion pulse.
  assign done            = (r_state == S_DONE) && !abort;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; abort outranks the final advance.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_advance && (r_t == w_last_t)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Length capture on accepted start; tick counter steps on each advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_t     <= '0;
      r_len_q <= '0;
    end else if (w_accept) begin
      r_t     <= '0;
      r_len_q <= len;
    end else if (w_advance) begin
      r_t     <= r_t + T_W'(1);
    end
  end

`ifdef VFS_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating count of RUN cycles that did not advance the wavefront.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_accept) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_RUN) && !w_advance && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vertical_feed_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vertical_feed_scheduler
// Description : Directed self-checking bench for vertical_feed_scheduler.
//               Cycle n is the clock period ending at edge n; start is
//               driven in cycle 0. Outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vertical_feed_scheduler;

  localparam int COLS  = 16;
  localparam int LEN_W = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic [COLS-1:0]  rdy;
  logic [COLS-1:0]  pop;
  logic             pe_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] stall_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  vertical_feed_scheduler #(
    .COLS (COLS),
    .LEN_W(LEN_W),
    .CNT_W(CNT_W)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .len            (len),
    .abort          (abort),
    .fifo_RREADY_col(rdy),
    .fifo_RVALID_col(pop),
    .pe_en          (pe_en),
    .busy           (busy),
    .done           (done),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int exp_stall_cnt(input int n);
`ifdef VFS_STALL_CNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // One run: start in cycle 0, then cycles 1..ncyc checked against the
  // timing rules. A stall on st_col in cycle st_cyc delays later events by
  // one cycle when st_eff is set. An abort in ab_cyc kills the run.
  task automatic run_case(input string nm, input int ln, input int st_cyc,
                          input int st_col, input bit st_eff, input int ab_cyc,
                          input int done_cyc, input int exp_stall, input int ncyc);
    int              sh;
    int              rel;
    int              run_end;
    bit              stall_now;
    bit              ab_now;
    bit              ab_past;
    bit              quiet;
    logic [COLS-1:0] ep;
    @(posedge clk); #1;
    start = 1'b1;
    len   = ln[LEN_W-1:0];
    abort = 1'b0;
    rdy   = '1;
    @(negedge clk);
    chk({nm, "/c0 busy"}, 32'(busy), 32'd0);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      rdy   = '1;
      abort = (c == ab_cyc);
      if (c == st_cyc) rdy[st_col] = 1'b0;
      @(negedge clk);
      sh        = (st_eff && st_cyc >= 0 && c > st_cyc) ? 1 : 0;
      stall_now = st_eff && (c == st_cyc);
      ab_now    = (c == ab_cyc);
      ab_past   = (ab_cyc >= 0) && (c > ab_cyc);
      quiet     = stall_now || ab_now || ab_past;
      rel       = c - sh;
      run_end   = (ln > 0) ? (ln + COLS - 1 + sh) : 0;
      ep        = '0;
      for (int k = 0; k < COLS; k++) begin
        if (!quiet && rel >= 1 + k && rel <= k + ln) ep[k] = 1'b1;
      end
      chk($sformatf("%s/c%0d pop", nm, c), 32'(pop), 32'(ep));
      chk($sformatf("%s/c%0d pe_en", nm, c), 32'(pe_en),
          32'(!quiet && c <= run_end));
      chk($sformatf("%s/c%0d busy", nm, c), 32'(busy),
          32'(!ab_past && c <= run_end));
      chk($sformatf("%s/c%0d done", nm, c), 32'(done), 32'(c == done_cyc));
    end
    if (exp_stall >= 0) begin
      chk({nm, "/stall_cnt"}, 32'(stall_cnt), 32'(exp_stall_cnt(exp_stall)));
    end
  endtask

  initial begin
    int w;
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    len   = '0;
    rdy   = '1;

    // Reset state, with all columns ready to prove no pop leaks out.
    repeat (2) @(posedge clk);
    #1;
    chk("rst pop", 32'(pop), 32'd0);
    chk("rst pe_en", 32'(pe_en), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst stall_cnt", 32'(stall_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    // Abort while idle must do nothing.
    abort = 1'b1;
    @(negedge clk);
    chk("idle abort busy", 32'(busy), 32'd0);

    // Basic skewed sequence, then a stall on active col3 in cycle 4,
    // then a low ready on col15 while it is not yet active (no stall).
    run_case("base", 4, -1, 0, 1'b0, -1, 20, 0, 21);
    run_case("stall", 4, 4, 3, 1'b1, -1, 21, 1, 22);
    run_case("inact", 3, 2, 15, 1'b0, -1, 19, 0, 20);
    run_case("long", 255, -1, 0, 1'b0, -1, 271, 0, 272);

    // Abort mid-run, then a clean follow-up run.
    run_case("abort", 8, -1, 0, 1'b0, 10, -1, -1, 13);
    run_case("post", 2, -1, 0, 1'b0, -1, 18, 0, 19);

    // len=0: done in cycle 1; start in cycle 1 ignored, in cycle 2 taken.
    @(posedge clk); #1;
    start = 1'b1;
    len   = 8'd0;
    @(posedge clk); #1;
    len   = 8'd2;
    @(negedge clk);
    chk("len0 c1 done", 32'(done), 32'd1);
    chk("len0 c1 pop", 32'(pop), 32'd0);
    chk("len0 c1 busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("len0 c2 done", 32'(done), 32'd0);
    chk("len0 c2 busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("len0 c3 busy", 32'(busy), 32'd1);
    chk("len0 c3 pop", 32'(pop), 32'h0001);
    w = 0;
    while (!done && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("len0 restart done delay", 32'(w), 32'd17);

    // Asynchronous reset in the middle of a len=8 run.
    @(posedge clk); #1;
    start = 1'b1;
    len   = 8'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("arst pre pop", 32'(pop), 32'h001F);
    #2;
    rst = 1'b0;
    #1;
    chk("arst pop", 32'(pop), 32'd0);
    chk("arst pe_en", 32'(pe_en), 32'd0);
    chk("arst busy", 32'(busy), 32'd0);
    chk("arst done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_case("after_rst", 1, -1, 0, 1'b0, -1, 17, 0, 18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
